// File: rtl/packet_pkg.sv
// Shared packet types and default widths for the switch datapath.
package packet_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] source;
    logic [ADDR_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  typedef enum logic {
    HS_EMPTY = 1'b0,
    HS_REQ   = 1'b1
  } head_state_e;

endpackage

// File: rtl/switch_ingress_queue_if.sv
// Ingress packet bus plus egress request/grant handshake of one switch port.
interface switch_ingress_queue_if
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH
);
  logic                  valid_in;
  logic                  ready_in;
  logic [ADDR_WIDTH-1:0] source_in;
  logic [ADDR_WIDTH-1:0] target_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [NUM_PORTS-1:0]  req_out;
  logic [NUM_PORTS-1:0]  gnt_in;
  logic [ADDR_WIDTH-1:0] source_out;
  logic [ADDR_WIDTH-1:0] target_out;
  logic [DATA_WIDTH-1:0] data_out;

  // Port pins and arbiter side
  modport master (
    output valid_in, source_in, target_in, data_in, gnt_in,
    input  ready_in, req_out, source_out, target_out, data_out
  );

  // Ingress queue side
  modport slave (
    input  valid_in, source_in, target_in, data_in, gnt_in,
    output ready_in, req_out, source_out, target_out, data_out
  );
endinterface

// File: rtl/switch_ingress_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/switch_ingress_queue.sv
// Per-port ingress queue: validates targets, buffers packets and requests
// the egress port of the head packet, discarding it on head-of-line timeout.
module switch_ingress_queue
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PORT_ID    = 0,
  parameter int TIMEOUT    = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  switch_ingress_queue_if.slave  bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic [CNT_WIDTH-1:0]   tmo_cnt
);
  localparam int FW       = 2 * ADDR_WIDTH + DATA_WIDTH;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int AGE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [ADDR_WIDTH:0]   NP  = (ADDR_WIDTH + 1)'(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] PID = ADDR_WIDTH'(PORT_ID);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic              accept, bad_tgt, gnt_hit, tmo_hit;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_wdata, fifo_rdata, head;
  logic [CW-1:0]     fifo_count;
  logic [NUM_PORTS-1:0] req_vec;

  head_state_e          state_q, state_d;
  logic [AGE_W-1:0]     age_q, age_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic [FW-1:0]        head_q, head_d;

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ingress handshake and target validation; self and out-of-range are dropped
  always_comb begin
    accept     = bus.valid_in && bus.ready_in;
    bad_tgt    = ({1'b0, bus.target_in} >= NP) || (bus.target_in == PID);
    fifo_push  = accept && !bad_tgt;
    fifo_wdata = {bus.source_in, bus.target_in, bus.data_in};
  end

  // Head request, grant match and timeout decision
  always_comb begin
    head    = fifo_empty ? head_q : fifo_rdata;
    req_vec = (state_q == HS_REQ) ? (NUM_PORTS'(1) << head[DATA_WIDTH +: ADDR_WIDTH]) : '0;
    gnt_hit = |(req_vec & bus.gnt_in);
    tmo_hit = (TIMEOUT > 0) && (state_q == HS_REQ) && !gnt_hit && (age_q == AGE_W'(TMO_LAST));
    fifo_pop = (state_q == HS_REQ) && (gnt_hit || tmo_hit);
  end

  // Head FSM next state, age and statistics
  always_comb begin
    state_d = state_q;
    age_d   = '0;
    drop_d  = drop_q;
    tmo_d   = tmo_q;
    head_d  = head;
    case (state_q)
      HS_EMPTY: if (fifo_push) state_d = HS_REQ;
      HS_REQ:   if (fifo_pop && !fifo_push && fifo_count == CW'(1)) state_d = HS_EMPTY;
      default:  state_d = HS_EMPTY;
    endcase
    if (TIMEOUT > 0 && state_q == HS_REQ && !fifo_pop) age_d = age_q + AGE_W'(1);
    if (accept && bad_tgt) drop_d = sat_inc(drop_q);
    if (tmo_hit)           tmo_d  = sat_inc(tmo_q);
  end

  // State, age, counters and held head value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HS_EMPTY;
      age_q   <= '0;
      drop_q  <= '0;
      tmo_q   <= '0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
      head_q  <= head_d;
    end
  end

  assign bus.ready_in   = !fifo_full;
  assign bus.req_out    = req_vec;
  assign bus.source_out = head[FW-1 -: ADDR_WIDTH];
  assign bus.target_out = head[DATA_WIDTH +: ADDR_WIDTH];
  assign bus.data_out   = head[DATA_WIDTH-1:0];
  assign count          = fifo_count;
  assign drop_cnt       = drop_q;
  assign tmo_cnt        = tmo_q;
endmodule

// File: doc/switch_ingress_queue.md
Name: switch_ingress_queue

Overview:
- Parametrised per-port ingress stage for the NUM_PORTS packet switch; successor to the fixed 4-port valid-only port interface.
- Adds valid/ready backpressure, a DEPTH-entry FIFO, target validation/drop, one-hot egress request/grant handshake, head-of-line timeout and statistics counters.
- One instance per switch port, between the port pins and the crossbar arbiter.

Parameters:
- NUM_PORTS, 4, number of switch ports (2..16).
- ADDR_WIDTH, packet_pkg::ADDR_WIDTH, width of source/target fields; must hold NUM_PORTS-1.
- DATA_WIDTH, packet_pkg::DATA_WIDTH, payload width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- PORT_ID, 0, index of this port.
- TIMEOUT, 0, cycles a head packet may wait for grant before discard; 0 disables.
- CNT_WIDTH, 8, width of statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  ingress packet valid
- ready_in  out  1  ingress can accept
- source_in  in  ADDR_WIDTH  ingress source
- target_in  in  ADDR_WIDTH  ingress target
- data_in  in  DATA_WIDTH  ingress payload
- req_out  out  NUM_PORTS  one-hot request toward egress target of head packet
- gnt_in  in  NUM_PORTS  grant from arbiter
- source_out  out  ADDR_WIDTH  head packet source
- target_out  out  ADDR_WIDTH  head packet target
- data_out  out  DATA_WIDTH  head packet payload
- count  out  $clog2(DEPTH)+1  occupancy
- drop_cnt  out  CNT_WIDTH  packets dropped at ingress (bad target)
- tmo_cnt  out  CNT_WIDTH  packets discarded by timeout

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n sampled on posedge clk).
- Reset: FIFO empty, count=0, ready_in=1, req_out=0, source_out/target_out/data_out=0, drop_cnt=0, tmo_cnt=0, age counter=0, FSM=EMPTY. Reset mid-operation discards all queued packets; the packet on the ingress bus in that cycle is not accepted.
- ready_in = (count != DEPTH); combinational from registered count only, never from valid_in or gnt_in.
- Accept = valid_in && ready_in at posedge. Accepted packet is dropped (drop_cnt++) if target_in >= NUM_PORTS or target_in == PORT_ID; otherwise enqueued.
- First-word-fall-through. A packet accepted at edge N into an empty queue drives the head outputs and req_out from after edge N.
- Head FSM:
  - EMPTY: req_out=0. Go to REQ when count becomes nonzero.
  - REQ: req_out = 1<<target_out.
    - Pop when gnt_in[target_out]=1. Go to EMPTY if the queue becomes empty, else stay in REQ with the next head and age reset to 0.
    - gnt_in bits other than target_out are ignored. gnt_in while EMPTY is ignored.
  - Timeout (TIMEOUT>0): age increments each REQ cycle without grant. When age == TIMEOUT-1 and there is no grant, the head is popped at that edge, tmo_cnt++, and age is cleared. A grant in that same cycle wins: normal pop, no tmo_cnt.
- Simultaneous push and pop: both occur and count is unchanged. While full, ready_in=0, so a same-cycle pop does not admit a push; this keeps ready_in registered-only.
- Pointers wrap modulo DEPTH.
- Counters saturate at 2^CNT_WIDTH-1.
- Head outputs hold their last value while EMPTY. Only req_out is qualified.

Decomposition:
- packet_pkg holds ADDR_WIDTH, DATA_WIDTH, a packed struct pkt_t {source, target, data} and enum head_state_e {HS_EMPTY, HS_REQ}. The existing packet class stays TB-only (guarded by `ifndef SYNTHESIS`).
- Sub-module sync_fifo (params WIDTH=$bits(pkt_t), DEPTH): storage, pointers, count, full/empty.
- Validation, FSM, age and counters live in the top module.

Test Plan:
- Reset then single packet src=1 tgt=2 data=0xA5 on PORT_ID=0 -> req_out=4'b0100 the cycle after accept; gnt_in=4'b0100 for one cycle -> req_out=0, count=0.
- Fill: 5 back-to-back packets, DEPTH=4, no grants -> first 4 accepted, ready_in=0 at count=4, 5th held until one gnt, then accepted in order.
- Bad targets: tgt=0 (self) and tgt=5 with NUM_PORTS=4, ADDR_WIDTH=3 -> both handshakes complete, drop_cnt=2, count=0, req_out stays 0.
- TIMEOUT=3, one packet, no grant -> discarded after 3 REQ cycles, tmo_cnt=1. Repeat with grant in the 3rd cycle -> normal pop, tmo_cnt unchanged.
- Wrong-bit grant: head tgt=3, gnt_in=4'b0010 -> no pop, count unchanged. Also push+grant same cycle at count=2 -> count stays 2, order preserved.
- Reset asserted with count=3 and valid_in=1 -> next cycle count=0, req_out=0, counters 0, ready_in=1.
